// File: rtl/gray_slot_scheduler.sv
// gray_slot_scheduler
//   Round-robin time-slot sequencer for a shared gray-coded slot counter.
//   It grants one requester at a time. A slot lasts slot_len cycles, where
//   0 means 2^CBITS cycles, or ends early when the owner drops its request.
//   After each slot there is exactly one HANDOFF cycle. In that cycle the
//   round-robin pointer moves past the last owner and the next winner is
//   chosen.
// Ports:
//   clk, rst    clock / async active-high reset
//   req         per-requester request levels
//   slot_len    slot length, sampled when a grant is made
//   gnt         one-hot grant, zero outside ACTIVE
//   gnt_id      index of current or last owner
//   gray_c      gray code of the slot counter
//   slot_done   pulse in the final cycle of a slot
//   busy        high while a slot is active
module gray_slot_scheduler #(
  parameter int NREQ  = 4,
  parameter int CBITS = 9,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [CBITS-1:0] slot_len,
  output logic [NREQ-1:0]  gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic [CBITS-1:0] gray_c,
  output logic             slot_done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HANDOFF} state_t;

  state_t           state, state_nxt;
  logic [CBITS-1:0] cnt, len;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   win;
  logic             found;
  logic             term, release_c;

  // Search for the first request, starting at ptr and wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  // len - 1 wraps to all-ones when len is 0, which gives a full 2^CBITS slot.
  assign term      = (cnt == len - CBITS'(1));
  assign release_c = !req[gnt_id];
  assign ptr_nxt   = IDW'((int'(gnt_id) + 1) % NREQ);

  always_comb begin
    state_nxt = state;
    slot_done = 1'b0;
    unique case (state)
      IDLE, HANDOFF: state_nxt = found ? ACTIVE : IDLE;
      ACTIVE: begin
        if (term || release_c) begin
          slot_done = 1'b1;
          state_nxt = HANDOFF;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      len    <= '0;
      ptr    <= '0;
      gnt_id <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE, HANDOFF: begin
          cnt <= '0;
          if (found) begin
            gnt_id <= win;
            len    <= slot_len;
          end
        end
        ACTIVE: begin
          if (slot_done) begin
            cnt <= '0;
            // The pointer is updated here, so HANDOFF already arbitrates
            // from the slot after the last owner.
            ptr <= ptr_nxt;
          end else begin
            cnt <= cnt + CBITS'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign busy   = (state == ACTIVE);
  assign gray_c = cnt ^ (cnt >> 1);

  always_comb begin
    gnt = '0;
    if (busy) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: tb/tb_gray_slot_scheduler.sv
module tb_gray_slot_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [8:0] slot_len;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [8:0] gray_c;
  logic       slot_done, busy;

  // Small-counter instance that exercises the 2^CBITS slot length.
  logic [3:0] req3;
  logic [2:0] slot_len3;
  logic [3:0] gnt3;
  logic [1:0] gnt_id3;
  logic [2:0] gray_c3;
  logic       slot_done3, busy3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gray_slot_scheduler #(.NREQ(4), .CBITS(9)) dut (
    .clk(clk), .rst(rst), .req(req), .slot_len(slot_len),
    .gnt(gnt), .gnt_id(gnt_id), .gray_c(gray_c),
    .slot_done(slot_done), .busy(busy));

  gray_slot_scheduler #(.NREQ(4), .CBITS(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .slot_len(slot_len3),
    .gnt(gnt3), .gnt_id(gnt_id3), .gray_c(gray_c3),
    .slot_done(slot_done3), .busy(busy3));

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req = '0; req3 = '0; slot_len = '0; slot_len3 = '0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = '0; req3 = '0; slot_len = 9'd3; slot_len3 = '0;
    rst = 1'b1;
    #3;
    checks++;
    if ({gnt, gnt_id, gray_c, slot_done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b id=%0d gray=%0d done=%b busy=%b, want all 0",
               gnt, gnt_id, gray_c, slot_done, busy);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [8:0] exp_gray [3];
    exp_gray[0] = 9'd0;
    exp_gray[1] = 9'd1;
    exp_gray[2] = 9'd3;
    do_reset();
    req = 4'b0010; slot_len = 9'd3;
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_gnt c%0d: got gnt=%b id=%0d busy=%b, want 0010 1 1", c, gnt, gnt_id, busy);
      end
      checks++;
      if (gray_c !== exp_gray[c] || slot_done !== (c == 2)) begin
        errors++;
        $display("FAIL basic_gray c%0d: got gray=%0d done=%b, want %0d %b",
                 c, gray_c, slot_done, exp_gray[c], (c == 2));
      end
      slot_len = 9'd7;  // a change during the slot must have no effect
    end
    req = 4'b0000;
    cyc();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || gray_c !== 9'd0 || slot_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_handoff: got gnt=%b busy=%b gray=%0d done=%b, want 0 0 0 0", gnt, busy, gray_c, slot_done);
    end
    cyc();
    checks++;
    if (gnt !== 4'b0 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL basic_idle: got gnt=%b id=%0d, want 0000 1", gnt, gnt_id);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111; slot_len = 9'd2;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp;
      exp = 4'b0001 << (k % 4);
      cyc();
      checks++;
      if (gnt !== exp || slot_done !== 1'b0) begin
        errors++;
        $display("FAIL rr_first k%0d: got gnt=%b done=%b, want %b 0", k, gnt, slot_done, exp);
      end
      cyc();
      checks++;
      if (gnt !== exp || slot_done !== 1'b1) begin
        errors++;
        $display("FAIL rr_last k%0d: got gnt=%b done=%b, want %b 1", k, gnt, slot_done, exp);
      end
      cyc();
      checks++;
      if (gnt !== 4'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap k%0d: got gnt=%b busy=%b, want 0000 0", k, gnt, busy);
      end
    end
    req = '0;
  endtask

  task automatic test_full_len();
    logic [2:0] exp_g [8];
    exp_g[0] = 3'd0; exp_g[1] = 3'd1; exp_g[2] = 3'd3; exp_g[3] = 3'd2;
    exp_g[4] = 3'd6; exp_g[5] = 3'd7; exp_g[6] = 3'd5; exp_g[7] = 3'd4;
    do_reset();
    req3 = 4'b0001; slot_len3 = 3'd0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      checks++;
      if (gnt3 !== 4'b0001 || gray_c3 !== exp_g[c] || slot_done3 !== (c == 7)) begin
        errors++;
        $display("FAIL full_len c%0d: got gnt=%b gray=%0d done=%b, want 0001 %0d %b",
                 c, gnt3, gray_c3, slot_done3, exp_g[c], (c == 7));
      end
    end
    req3 = '0;
    cyc();
    checks++;
    if (gnt3 !== 4'b0 || slot_done3 !== 1'b0) begin
      errors++;
      $display("FAIL full_len_end: got gnt=%b done=%b, want 0000 0", gnt3, slot_done3);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0011; slot_len = 9'd5;
    cyc();
    cyc();
    req = 4'b0010;  // owner drops its request at cnt=1
    #1;
    checks++;
    if (slot_done !== 1'b1 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL early_done: got done=%b gnt=%b, want 1 0001", slot_done, gnt);
    end
    cyc();
    checks++;
    if (gnt !== 4'b0 || slot_done !== 1'b0) begin
      errors++;
      $display("FAIL early_handoff: got gnt=%b done=%b, want 0000 0", gnt, slot_done);
    end
    cyc();
    checks++;
    if (gnt !== 4'b0010 || gray_c !== 9'd0) begin
      errors++;
      $display("FAIL early_next: got gnt=%b gray=%0d, want 0010 0", gnt, gray_c);
    end
    req = '0;
  endtask

  task automatic test_term_and_release();
    do_reset();
    req = 4'b0101; slot_len = 9'd2;
    cyc();
    cyc();
    req = 4'b0100;  // drop at cnt=1, which is also the terminal cycle
    #1;
    checks++;
    if (slot_done !== 1'b1) begin
      errors++;
      $display("FAIL both_done: got done=%b, want 1", slot_done);
    end
    cyc();
    checks++;
    if (slot_done !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL both_single: got done=%b gnt=%b, want 0 0000", slot_done, gnt);
    end
    cyc();
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL both_next: got gnt=%b id=%0d, want 0100 2", gnt, gnt_id);
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001; slot_len = 9'd10;
    for (int c = 0; c < 5; c++) cyc();
    checks++;
    if (gray_c !== 9'd6 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL arst_pre: got gray=%0d gnt=%b, want 6 0001", gray_c, gnt);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || gray_c !== 9'd0 || slot_done !== 1'b0) begin
      errors++;
      $display("FAIL arst_now: got gnt=%b busy=%b gray=%0d done=%b, want 0 0 0 0", gnt, busy, gray_c, slot_done);
    end
    cyc();
    rst = 1'b0;
    req = 4'b1000;
    cyc();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL arst_wrap: got gnt=%b id=%0d, want 1000 3", gnt, gnt_id);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_full_len();
    test_early_release();
    test_term_and_release();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_slot_scheduler.md
Name: gray_slot_scheduler

Overview:
- Round-robin time-slot scheduler that shares one gray-coded slot counter among NREQ requesters.
- Grants one requester at a time for a programmable number of cycles and exposes the counter as gray code.
- Emits a slot-done event at the end of each slot.
- Sits in front of the gray-counter datapath as its sequencer.
- Guarantees liveness: every continuously held request is eventually granted.

Parameters:
- NREQ, 4, number of requesters (>=2).
- CBITS, 9, slot counter width.
- IDW, $clog2(NREQ), derived; width of gnt_id.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester request level; held high while the slot is wanted.
- slot_len  input  CBITS  slot length in cycles; sampled only at grant; 0 means 2^CBITS.
- gnt  output  NREQ  one-hot grant; all-zero when no slot is active.
- gnt_id  output  IDW  index of current/last owner.
- gray_c  output  CBITS  cnt ^ (cnt >> 1) of the internal slot counter.
- slot_done  output  1  one-cycle pulse in the final cycle of a slot.
- busy  output  1  high in ACTIVE.

Behaviour:
- Reset (async, immediate): state IDLE, cnt 0, len 0, ptr 0.
- Outputs at reset: gnt 0, gnt_id 0, gray_c 0, slot_done 0, busy 0.
- Reset mid-slot aborts the slot with no slot_done.
- States: IDLE, ACTIVE, HANDOFF.
- IDLE: gnt 0. If any req bit is high at edge t, the next state is ACTIVE at t+1.
  - Winner = first set req bit searching ptr, ptr+1, ... mod NREQ.
  - At t+1: gnt one-hot for the winner, gnt_id = winner, len latched from slot_len, cnt = 0.
- ACTIVE:
  - cnt increments by 1 each cycle, mod 2^CBITS.
  - gray_c is combinational from cnt; the first ACTIVE cycle shows gray 0.
  - Terminal cycle: cnt == len-1 (mod 2^CBITS). len 0 gives terminal at all-ones, i.e. 2^CBITS cycles.
  - Early release: req[gnt_id] low in any ACTIVE cycle ends the slot in that cycle.
  - In the terminal or release cycle: slot_done = 1; next state HANDOFF.
  - Terminal and release in the same cycle produce exactly one slot_done pulse.
  - slot_len changes during ACTIVE are ignored.
  - Other requesters' req bits have no effect during ACTIVE; no preemption.
- HANDOFF (exactly 1 cycle):
  - gnt 0, busy 0, cnt held at 0.
  - ptr = (gnt_id + 1) mod NREQ.
  - Arbitration as in IDLE using the updated ptr: a pending req goes to ACTIVE next cycle, otherwise IDLE.
  - Consequence: at least one idle cycle between consecutive grants, even to the same requester.
- gnt_id holds its value through HANDOFF and IDLE.
- Latency: req rising in IDLE gives gnt 1 cycle later.
- Fairness bound: a req held high is granted within (NREQ-1)*(2^CBITS+1)+1 cycles.
- Required property: if rst is eventually permanently low, a req held high is eventually granted.
- Required invariants: gnt is one-hot-or-zero; busy == |gnt.
- Required invariant: slot_done only while busy.

Test Plan:
- Reset then req=4'b0010, slot_len=3: gnt=0010 from cycle 1 to 3; gray_c 0,1,3.
  - slot_done at cycle 3; HANDOFF at cycle 4; IDLE at cycle 5.
- req=4'b1111 held, slot_len=2: grants 0001, 0010, 0100, 1000, 0001 in order, each 2 cycles long.
  - 1 gap cycle between grants; ptr wraps 3->0.
- CBITS=3, slot_len=0: slot lasts 8 cycles.
  - gray_c sequence 0,1,3,2,6,7,5,4; slot_done when cnt=7.
- Early release: owner drops req at cnt=1 with slot_len=5: slot_done in that cycle, gnt=0 next cycle.
  - Next pending requester granted one cycle later.
- Simultaneous terminal and release (slot_len=2, req drops at cnt=1): single slot_done pulse, same successor as a normal end.
- Async rst asserted at cnt=4 of an active slot:
  - gnt, busy, gray_c go 0 immediately; no slot_done.
  - After release, req=4'b1000 is granted from ptr 0 (search wraps to index 3).
